// File: rtl/dac_pingpong_player_pkg.sv
// Shared types, defaults and sample-code conversion for the ping-pong DAC player
// and its ADC capture counterpart.
package dac_pingpong_player_pkg;

  localparam int unsigned DAC_DW = 10;
  localparam int unsigned DAC_AW = 10;
  localparam logic [DAC_DW-1:0] DAC_IDLE_CODE = 10'd512;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_PLAY = 1'b1
  } player_state_e;

  // Two's complement <-> offset binary; the mapping is its own inverse.
  function automatic logic [DAC_DW-1:0] to_offset_binary(input logic [DAC_DW-1:0] s);
    return {~s[DAC_DW-1], s[DAC_DW-2:0]};
  endfunction

endpackage

// File: rtl/dac_pingpong_player_if.sv
// Fill-side handshake and DAC-side stream of the ping-pong player.
interface dac_pingpong_player_if #(
  parameter int unsigned DW = dac_pingpong_player_pkg::DAC_DW
);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          play_en;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          frame_start;
  logic          underrun;
  logic          active_buf;

  modport master (
    output wr_valid, wr_data, play_en,
    input  wr_ready, dac_data, dac_valid, frame_start, underrun, active_buf
  );

  modport slave (
    input  wr_valid, wr_data, play_en,
    output wr_ready, dac_data, dac_valid, frame_start, underrun, active_buf
  );
endinterface

// File: rtl/dac_pingpong_player_frame_buf.sv
// One frame of sample storage: simple dual-port RAM with a registered read.
module dac_frame_buf #(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/dac_pingpong_player.sv
// Ping-pong frame player: loads frames into the idle buffer, streams the active one
// to the DAC. Optional underrun counter port enabled by DAC_UNDERRUN_CNT_EN.
module dac_pingpong_player import dac_pingpong_player_pkg::*; #(
  parameter int unsigned     DW        = DAC_DW,
  parameter int unsigned     AW        = DAC_AW,
  parameter logic [DW-1:0]   IDLE_CODE = DAC_IDLE_CODE
) (
  input  logic                 clk_5_12M,
  input  logic                 rst_real,
  dac_pingpong_player_if.slave bus
`ifdef DAC_UNDERRUN_CNT_EN
  , output logic [15:0]        underrun_cnt
`endif
);
  localparam int unsigned   DEPTH = 2**AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  player_state_e state_q, state_d;
  logic          active_q, active_d;
  logic          fill_full_q, fill_full_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          accept;
  logic          swap;

  logic [DW-1:0] rdata0, rdata1;
  logic          s1_valid, s1_start, s1_under, s1_sel;
  logic [DW-1:0] dac_data_q;
  logic          dac_valid_q, frame_start_q, underrun_q;

  assign accept = bus.wr_valid && !fill_full_q;

  // Control registers
  always_ff @(posedge clk_5_12M or negedge rst_real) begin
    if (!rst_real) begin
      state_q     <= P_IDLE;
      active_q    <= 1'b0;
      fill_full_q <= 1'b0;
      pend_q      <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      fill_full_q <= fill_full_d;
      pend_q      <= pend_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  // Fill addressing and player next-state; swaps only at frame boundaries
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    fill_full_d = fill_full_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    pend_d      = 1'b0;
    swap        = 1'b0;

    if (accept) begin
      wr_addr_d = wr_addr_q + AW'(1);
      if (wr_addr_q == LAST) fill_full_d = 1'b1;
    end

    unique case (state_q)
      P_IDLE: begin
        rd_addr_d = '0;
        if (bus.play_en && fill_full_q) begin
          swap    = 1'b1;
          state_d = P_PLAY;
        end
      end
      P_PLAY: begin
        rd_addr_d = rd_addr_q + AW'(1);
        if (rd_addr_q == LAST) begin
          if (!bus.play_en)    state_d = P_IDLE;
          else if (fill_full_q) swap   = 1'b1;
          else                  pend_d = 1'b1;
        end
      end
      default: state_d = P_IDLE;
    endcase

    // The fill side is full whenever a swap happens, so no write collides with it
    if (swap) begin
      active_d    = ~active_q;
      fill_full_d = 1'b0;
    end
  end

  dac_frame_buf #(.DW(DW), .AW(AW)) u_buf0 (
    .clk   (clk_5_12M),
    .we    (accept && active_q),
    .waddr (wr_addr_q),
    .wdata (bus.wr_data),
    .raddr (rd_addr_q),
    .rdata (rdata0)
  );

  dac_frame_buf #(.DW(DW), .AW(AW)) u_buf1 (
    .clk   (clk_5_12M),
    .we    (accept && !active_q),
    .waddr (wr_addr_q),
    .wdata (bus.wr_data),
    .raddr (rd_addr_q),
    .rdata (rdata1)
  );

  // Two-stage output pipeline: flags ride alongside the RAM read, then the output register
  always_ff @(posedge clk_5_12M or negedge rst_real) begin
    if (!rst_real) begin
      s1_valid      <= 1'b0;
      s1_start      <= 1'b0;
      s1_under      <= 1'b0;
      s1_sel        <= 1'b0;
      dac_data_q    <= IDLE_CODE;
      dac_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      s1_valid      <= (state_q == P_PLAY);
      s1_start      <= (state_q == P_PLAY) && (rd_addr_q == '0);
      s1_under      <= pend_q;
      s1_sel        <= active_q;
      dac_valid_q   <= s1_valid;
      frame_start_q <= s1_start;
      underrun_q    <= s1_under;
      dac_data_q    <= s1_valid ? to_offset_binary(s1_sel ? rdata1 : rdata0) : IDLE_CODE;
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  // Saturating count of underrun pulses, cleared only by reset
  always_ff @(posedge clk_5_12M or negedge rst_real) begin
    if (!rst_real)                              underrun_cnt <= 16'd0;
    else if (s1_under && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

  assign bus.wr_ready    = ~fill_full_q;
  assign bus.dac_data    = dac_data_q;
  assign bus.dac_valid   = dac_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;
  assign bus.active_buf  = active_q;

endmodule

// File: tb/tb_dac_pingpong_player.sv
// Randomized bench for dac_pingpong_player against a frame-level playback model.
`timescale 1ns/1ps
module tb_dac_pingpong_player;

  localparam int DEPTH = 1024;

  typedef struct {
    bit v;
    int d;
    bit s;
    bit u;
  } slot_t;

  logic clk_5_12M = 1'b0;
  logic rst_real;
  dac_pingpong_player_if #(.DW(10)) bus ();
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  dac_pingpong_player dut (
    .clk_5_12M (clk_5_12M),
    .rst_real  (rst_real),
    .bus       (bus)
`ifdef DAC_UNDERRUN_CNT_EN
    , .underrun_cnt (underrun_cnt)
`endif
  );

  always #98 clk_5_12M = ~clk_5_12M;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: two frame stores, which one plays, how full the other is, play position
  int    m_buf [2][DEPTH];
  int    m_act, m_fill, m_idx, m_ucnt, m_utot;
  bit    m_play, m_under;
  slot_t p0, p1, expv;
  int    drv;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic slot_t idle_slot();
    slot_t s;
    s.v = 1'b0; s.d = 512; s.s = 1'b0; s.u = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    m_act = 0; m_fill = 0; m_idx = 0; m_ucnt = 0;
    m_play = 1'b0; m_under = 1'b0;
    p0 = idle_slot(); p1 = idle_slot();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dac_data"},    int'(bus.dac_data), 512);
    chk({tag, "_dac_valid"},   int'(bus.dac_valid), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_underrun"},    int'(bus.underrun), 0);
    chk({tag, "_active_buf"},  int'(bus.active_buf), 0);
    chk({tag, "_wr_ready"},    int'(bus.wr_ready), 1);
`ifdef DAC_UNDERRUN_CNT_EN
    chk({tag, "_underrun_cnt"}, int'(underrun_cnt), 0);
`endif
  endtask

  task automatic do_swap();
    m_act  = 1 - m_act;
    m_fill = 0;
    m_idx  = 0;
    m_play = 1'b1;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic tick();
    slot_t sl;
    bit    old_full, nu;
    @(posedge clk_5_12M);
    old_full = (m_fill == DEPTH);
    sl = idle_slot();
    if (m_play) begin
      sl.v = 1'b1;
      sl.d = m_buf[m_act][m_idx] + 512;
      sl.s = (m_idx == 0);
      sl.u = m_under;
    end
    nu = 1'b0;
    if (bus.wr_valid && !old_full) begin
      m_buf[1 - m_act][m_fill] = drv;
      m_fill++;
    end
    if (!m_play) begin
      if (bus.play_en && old_full) do_swap();
    end else if (m_idx == DEPTH - 1) begin
      if (!bus.play_en) begin
        m_play = 1'b0;
        m_idx  = 0;
      end else if (old_full) begin
        do_swap();
      end else begin
        m_idx  = 0;
        nu     = 1'b1;
        m_utot++;
      end
    end else begin
      m_idx++;
    end
    m_under = nu;
    p1 = p0;
    p0 = sl;
    expv = p1;
    if (expv.u && m_ucnt < 65535) m_ucnt++;
    #1;
    chk("dac_data",    int'(bus.dac_data), expv.d);
    chk("dac_valid",   int'(bus.dac_valid), int'(expv.v));
    chk("frame_start", int'(bus.frame_start), int'(expv.s));
    chk("underrun",    int'(bus.underrun), int'(expv.u));
    chk("active_buf",  int'(bus.active_buf), m_act);
    chk("wr_ready",    int'(bus.wr_ready), int'(m_fill < DEPTH));
`ifdef DAC_UNDERRUN_CNT_EN
    chk("underrun_cnt", int'(underrun_cnt), m_ucnt);
`endif
  endtask

  // mode 0: ramp index-512, 1: constant +100, 2: random; gaps: random idle cycles
  task automatic load_frame(input int mode, input bit gaps);
    int n = 0;
    while (m_fill < DEPTH && n < 5000) begin
      bus.wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (mode)
        0:       drv = m_fill - 512;
        1:       drv = 100;
        default: drv = int'($urandom_range(0, 1023)) - 512;
      endcase
      bus.wr_data = 10'(drv);
      tick();
      n++;
    end
    bus.wr_valid = 1'b0;
    chk("load_in_time", int'(n < 5000), 1);
  endtask

  task automatic wait_pos(input int act, input int idx);
    int n = 0;
    while (!(m_play && m_act == act && m_idx == idx) && n < 5000) begin
      tick();
      n++;
    end
    chk("wait_pos_in_time", int'(n < 5000), 1);
  endtask

  task automatic wait_stop();
    int n = 0;
    while (m_play && n < 3000) begin
      tick();
      n++;
    end
    chk("stop_in_time", int'(n < 3000), 1);
  endtask

  initial begin
    int u0, n;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.play_en  = 1'b0;
    rst_real     = 1'b0;
    drv          = 0;
    m_utot       = 0;
    model_reset();
    #250;
    chk_reset("rst");
    @(negedge clk_5_12M);
    rst_real = 1'b1;

    // Playback requested with nothing loaded: stays idle
    bus.play_en = 1'b1;
    repeat (40) tick();
    bus.play_en = 1'b0;

    // Ramp frame with random gaps, then a full buffer must hold off further writes
    load_frame(0, 1'b1);
    bus.wr_valid = 1'b1;
    repeat (20) tick();
    bus.wr_valid = 1'b0;

    // Ramp plays; second frame lands mid-replay, giving one underrun then a seamless swap
    bus.play_en = 1'b1;
    wait_pos(1, 900);
    load_frame(1, 1'b0);

    // Frame whose last write coincides with the boundary decision: replay, then swap
    wait_pos(0, 0);
    load_frame(2, 1'b0);

    // Drop play_en mid-frame: frame completes, then idle
    wait_pos(1, 300);
    bus.play_en = 1'b0;
    wait_stop();
    repeat (30) tick();

    // Single frame replayed: at least three consecutive underruns
    load_frame(2, 1'b1);
    bus.play_en = 1'b1;
    u0 = m_utot;
    n  = 0;
    while (m_utot < u0 + 3 && n < 6000) begin
      tick();
      n++;
    end
    chk("three_underruns_in_time", int'(n < 6000), 1);

    // Asynchronous reset in the middle of a frame
    wait_pos(0, 500);
    #3 rst_real = 1'b0;
    #1;
    bus.play_en = 1'b0;
    model_reset();
    chk_reset("rst_mid");
    repeat (2) @(posedge clk_5_12M);
    @(negedge clk_5_12M);
    rst_real = 1'b1;

    // Random fill traffic with continuous playback
    bus.play_en = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      drv = int'($urandom_range(0, 1023)) - 512;
      bus.wr_data = 10'(drv);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.play_en  = 1'b0;
    wait_stop();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
